// File: rtl/universal_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | universal_shift_reg                                                      |
// | WIDTH-bit hold / shift-right / shift-left / parallel-load register with  |
// | a per-word shift counter and a registered word_done pulse.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [1:0]       C_MODE_HOLD  = 2'b00;
  localparam logic [1:0]       C_MODE_RIGHT = 2'b01;
  localparam logic [1:0]       C_MODE_LEFT  = 2'b10;
  localparam logic [1:0]       C_MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             w_shift;

  // Both shift directions feed the same word counter.
  assign w_shift = en && ((mode == C_MODE_RIGHT) || (mode == C_MODE_LEFT));

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode)
        C_MODE_HOLD:  q_d = q_q;
        C_MODE_RIGHT: q_d = {ser_in_r, q_q[WIDTH-1:1]};
        C_MODE_LEFT:  q_d = {q_q[WIDTH-2:0], ser_in_l};
        C_MODE_LOAD:  begin
          q_d   = par_in;
          cnt_d = '0;
        end
        default:      q_d = q_q;
      endcase
    end
    if (w_shift) begin
      if (cnt_q == C_CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign par_out   = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign shift_cnt = cnt_q;
  assign word_done = done_q;

endmodule
`default_nettype wire
